// File: rtl/alu_regfile_pipe.sv
// Two-stage execute/write-back datapath: register file with two operand ports and a
// debug port, immediate operand, S1 result forwarding, and a registered ALU with flags.
module alu_regfile_pipe #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  input  logic [3:0]       ALU_OP,
  input  logic [AW-1:0]    R_Addr_A,
  input  logic [AW-1:0]    R_Addr_B,
  input  logic [AW-1:0]    W_Addr,
  input  logic             Write_Reg,
  input  logic             Use_Imm,
  input  logic [WIDTH-1:0] Imm,
  input  logic             Clear_Flags,
  input  logic [AW-1:0]    R_Addr_C,
  output logic [WIDTH-1:0] R_Data_C,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Result,
  output logic             ZF,
  output logic             OF,
  output logic             CF,
  output logic             OF_Sticky
);

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_XOR  = 4'd2,
    OP_NOR  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLTU = 4'd10,
    OP_PASS = 4'd11
  } alu_op_e;

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [WIDTH-1:0] rf_d [DEPTH];

  logic             s1_valid_q, s1_valid_d;
  alu_op_e          s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [AW-1:0]    s1_waddr_q, s1_waddr_d;
  logic             s1_wen_q,   s1_wen_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zf_q, zf_d, of_q, of_d, cf_q, cf_d;
  logic             sticky_q,    sticky_d;

  logic [WIDTH-1:0] alu_f;
  logic             alu_of, alu_cf;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [SW-1:0]    shamt;

  logic             s1_fwd_ok, fwd_a, fwd_b;
  logic [WIDTH-1:0] rf_a, rf_b, op_a, op_b;

  // Extended ALU on the S1 operands; diff_ext's top bit is the unsigned borrow.
  always_comb begin
    alu_f    = '0;
    alu_of   = 1'b0;
    alu_cf   = 1'b0;
    sum_ext  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    shamt    = s1_a_q[SW-1:0];
    case (s1_op_q)
      OP_AND:  alu_f = s1_a_q & s1_b_q;
      OP_OR:   alu_f = s1_a_q | s1_b_q;
      OP_XOR:  alu_f = s1_a_q ^ s1_b_q;
      OP_NOR:  alu_f = ~(s1_a_q | s1_b_q);
      OP_ADD: begin
        {alu_cf, alu_f} = sum_ext;
        alu_of = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (alu_f[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SUB: begin
        {alu_cf, alu_f} = diff_ext;
        alu_of = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (alu_f[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OP_SLT:  alu_f = WIDTH'($signed(s1_a_q) < $signed(s1_b_q));
      OP_SLL:  alu_f = s1_b_q << shamt;
      OP_SRL:  alu_f = s1_b_q >> shamt;
      OP_SRA:  alu_f = $unsigned($signed(s1_b_q) >>> shamt);
      OP_SLTU: alu_f = WIDTH'(s1_a_q < s1_b_q);
      OP_PASS: alu_f = s1_a_q;
      default: alu_f = '0;
    endcase
  end

  // Operand fetch: S1's pending write-back overrides the register file so that
  // back-to-back dependent operations see the architecturally current value.
  always_comb begin
    s1_fwd_ok = s1_valid_q && s1_wen_q;
    rf_a      = (R_Addr_A == '0) ? '0 : rf_q[R_Addr_A];
    rf_b      = (R_Addr_B == '0) ? '0 : rf_q[R_Addr_B];
    fwd_a     = s1_fwd_ok && (R_Addr_A != '0) && (R_Addr_A == s1_waddr_q);
    fwd_b     = s1_fwd_ok && (R_Addr_B != '0) && (R_Addr_B == s1_waddr_q);
    op_a      = fwd_a ? alu_f : rf_a;
    op_b      = Use_Imm ? Imm : (fwd_b ? alu_f : rf_b);
    R_Data_C  = (R_Addr_C == '0) ? '0 : rf_q[R_Addr_C];
  end

  // NOTE: combinational blocks use blocking '=' with a default for every signal first,
  // so later lines see earlier values and no path is left to infer a latch.
  always_comb begin
    s1_valid_d = In_Valid;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_waddr_d = s1_waddr_q;
    s1_wen_d   = s1_wen_q;
    if (In_Valid) begin
      s1_op_d    = alu_op_e'(ALU_OP);
      s1_a_d     = op_a;
      s1_b_d     = op_b;
      s1_waddr_d = W_Addr;
      s1_wen_d   = Write_Reg;
    end

    out_valid_d = s1_valid_q;
    result_d    = s1_valid_q ? alu_f          : result_q;
    zf_d        = s1_valid_q ? (alu_f == '0)  : zf_q;
    of_d        = s1_valid_q ? alu_of         : of_q;
    cf_d        = s1_valid_q ? alu_cf         : cf_q;

    // A new overflow beats a same-cycle clear.
    if (s1_valid_q && alu_of) sticky_d = 1'b1;
    else if (Clear_Flags)     sticky_d = 1'b0;
    else                      sticky_d = sticky_q;

    rf_d = rf_q;
    if (s1_valid_q && s1_wen_q && (s1_waddr_q != '0)) rf_d[s1_waddr_q] = alu_f;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_AND;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_waddr_q  <= '0;
      s1_wen_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_waddr_q  <= s1_waddr_d;
      s1_wen_q    <= s1_wen_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zf_q        <= zf_d;
      of_q        <= of_d;
      cf_q        <= cf_d;
      sticky_q    <= sticky_d;
    end
  end

  // NOTE: the register file must read zero after reset, so it is built from resettable
  // flops rather than an inferred RAM macro, which could not be cleared in one edge.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign Out_Valid = out_valid_q;
  assign Result    = result_q;
  assign ZF        = zf_q;
  assign OF        = of_q;
  assign CF        = cf_q;
  assign OF_Sticky = sticky_q;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Self-checking bench for alu_regfile_pipe: directed vector table, hand sequences for
// reset and sticky-flag corners, and random traffic against an in-order ISA model.
module tb_alu_regfile_pipe;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          In_Valid;
  logic [3:0]    ALU_OP;
  logic [AW-1:0] R_Addr_A, R_Addr_B, W_Addr, R_Addr_C;
  logic          Write_Reg, Use_Imm, Clear_Flags;
  logic [W-1:0]  Imm;
  logic [W-1:0]  R_Data_C, Result;
  logic          Out_Valid, ZF, OF, CF, OF_Sticky;

  alu_regfile_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .ALU_OP(ALU_OP),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr), .Write_Reg(Write_Reg),
    .Use_Imm(Use_Imm), .Imm(Imm), .Clear_Flags(Clear_Flags), .R_Addr_C(R_Addr_C),
    .R_Data_C(R_Data_C), .Out_Valid(Out_Valid), .Result(Result), .ZF(ZF), .OF(OF),
    .CF(CF), .OF_Sticky(OF_Sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view: mreg reflects every issued op in program order; creg only
  // the ops whose result has already come out (what R_Data_C should show).
  logic [W-1:0] mreg [D];
  logic [W-1:0] creg [D];

  bit           pv, pwr, pzf, pof, pcf;
  logic [W-1:0] pf;
  logic [AW-1:0] pwa;

  bit           exp_ov, exp_zf, exp_of, exp_cf, exp_st;
  logic [W-1:0] exp_res;

  function automatic void model_alu(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] f,
                                    output bit zf, output bit of, output bit cf);
    longint sa, sb, ua, ub, s, u, p, q;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = int'(a % 32);
    p  = longint'(1) << sh;
    f  = '0;
    of = 1'b0;
    cf = 1'b0;
    case (op)
      4'd0:  f = a & b;
      4'd1:  f = a | b;
      4'd2:  f = a ^ b;
      4'd3:  f = ~(a | b);
      4'd4: begin
        s  = sa + sb;
        u  = ua + ub;
        f  = u[31:0];
        of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cf = (u >= 64'sd4294967296);
      end
      4'd5: begin
        s  = sa - sb;
        u  = ua - ub;
        f  = u[31:0];
        of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        cf = (ua < ub);
      end
      4'd6:  f = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  begin u = ub * p; f = u[31:0]; end
      4'd8:  begin u = ub / p; f = u[31:0]; end
      4'd9:  begin
        q = (sb >= 0) ? (sb / p) : -((-sb + p - 1) / p);
        f = q[31:0];
      end
      4'd10: f = (ua < ub) ? 32'd1 : 32'd0;
      4'd11: f = a;
      default: f = '0;
    endcase
    zf = (f == '0);
  endfunction

  // One clock: model the issued op, drive it, cross the edge, then check what the
  // previous op produced plus the debug read port.
  task automatic step(input bit v, input logic [3:0] op, input logic [AW-1:0] ra,
                      input logic [AW-1:0] rb, input logic [AW-1:0] wa, input bit wr,
                      input bit ui, input logic [W-1:0] imm, input bit clr,
                      input logic [AW-1:0] rc);
    bit           cv, cwr, czf, cof, ccf;
    logic [W-1:0] a, b, cf_res;
    cv = v; cwr = 1'b0; czf = 1'b0; cof = 1'b0; ccf = 1'b0; cf_res = '0;
    if (v) begin
      a = (ra == 0) ? '0 : mreg[ra];
      b = ui ? imm : ((rb == 0) ? '0 : mreg[rb]);
      model_alu(op, a, b, cf_res, czf, cof, ccf);
      cwr = wr && (wa != 0);
      if (cwr) mreg[wa] = cf_res;
    end
    In_Valid = v; ALU_OP = op; R_Addr_A = ra; R_Addr_B = rb; W_Addr = wa;
    Write_Reg = wr; Use_Imm = ui; Imm = imm; Clear_Flags = clr; R_Addr_C = rc;
    @(posedge clk);
    #1;
    if (pv) begin
      exp_ov = 1'b1; exp_res = pf; exp_zf = pzf; exp_of = pof; exp_cf = pcf;
      if (pwr) creg[pwa] = pf;
    end else begin
      exp_ov = 1'b0;
    end
    if (pv && pof) exp_st = 1'b1;
    else if (clr)  exp_st = 1'b0;
    check("out_valid", W'(Out_Valid), W'(exp_ov));
    check("result",    Result,        exp_res);
    check("zf",        W'(ZF),        W'(exp_zf));
    check("of",        W'(OF),        W'(exp_of));
    check("cf",        W'(CF),        W'(exp_cf));
    check("of_sticky", W'(OF_Sticky), W'(exp_st));
    check($sformatf("r_data_c[%0d]", rc), R_Data_C, (rc == 0) ? '0 : creg[rc]);
    pv = cv; pf = cf_res; pzf = czf; pof = cof; pcf = ccf; pwr = cwr; pwa = wa;
  endtask

  task automatic idle(input bit clr, input logic [AW-1:0] rc);
    step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, '0, clr, rc);
  endtask

  // Assert reset away from a clock edge with In_Valid high, check the outputs clear at
  // once, hold for some edges, check every register reads zero, then release.
  task automatic do_reset(input int cycles);
    In_Valid = 1'b1;
    Write_Reg = 1'b1;
    Reset_n = 1'b0;
    #1;
    check("rst_out_valid", W'(Out_Valid), '0);
    check("rst_result",    Result,        '0);
    check("rst_flags",     W'({ZF, OF, CF}), '0);
    check("rst_of_sticky", W'(OF_Sticky), '0);
    repeat (cycles) @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) begin
      R_Addr_C = AW'(i);
      #0.1;
      check($sformatf("rst_reg[%0d]", i), R_Data_C, '0);
    end
    for (int i = 0; i < D; i++) begin
      mreg[i] = '0;
      creg[i] = '0;
    end
    pv = 1'b0; pwr = 1'b0; pf = '0; pzf = 1'b0; pof = 1'b0; pcf = 1'b0; pwa = '0;
    exp_ov = 1'b0; exp_res = '0; exp_zf = 1'b0; exp_of = 1'b0; exp_cf = 1'b0; exp_st = 1'b0;
    In_Valid = 1'b0;
    Reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] ra, rb, wa;
    bit            wr, ui;
    logic [W-1:0]  imm;
    logic [W-1:0]  res;
    bit            zf, of, cf;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic table_check(input int i);
    check($sformatf("tbl%0d_result", i), Result, vecs[i].res);
    check($sformatf("tbl%0d_flags", i), W'({ZF, OF, CF}), W'({vecs[i].zf, vecs[i].of, vecs[i].cf}));
  endtask

  initial begin
    //              op     ra  rb  wa  wr ui imm            result        zf of cf
    vecs[0]  = '{4'd1,  0,  0,  1,  1, 1, 32'd5,         32'd5,         0, 0, 0};
    vecs[1]  = '{4'd4,  1,  0,  2,  1, 1, 32'd3,         32'd8,         0, 0, 0};
    vecs[2]  = '{4'd1,  0,  0,  3,  1, 1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0};
    vecs[3]  = '{4'd4,  3,  0,  4,  1, 1, 32'd1,         32'h8000_0000, 0, 1, 0};
    vecs[4]  = '{4'd5,  0,  0,  5,  1, 1, 32'd1,         32'hFFFF_FFFF, 0, 0, 1};
    vecs[5]  = '{4'd6,  5,  0,  8,  1, 1, 32'd0,         32'd1,         0, 0, 0};
    vecs[6]  = '{4'd10, 5,  0,  9,  1, 1, 32'd0,         32'd0,         1, 0, 0};
    vecs[7]  = '{4'd1,  0,  0,  6,  1, 1, 32'd36,        32'd36,        0, 0, 0};
    vecs[8]  = '{4'd9,  6,  0, 10,  1, 1, 32'h8000_0000, 32'hF800_0000, 0, 0, 0};
    vecs[9]  = '{4'd8,  6,  0, 11,  1, 1, 32'h8000_0000, 32'h0800_0000, 0, 0, 0};
    vecs[10] = '{4'd1,  0,  0,  0,  1, 1, 32'h1234,      32'h1234,      0, 0, 0};
    vecs[11] = '{4'd7,  6,  0, 12,  1, 1, 32'd1,         32'h10,        0, 0, 0};
    vecs[12] = '{4'd4,  4,  0, 13,  1, 1, 32'h8000_0000, 32'd0,         1, 1, 1};
    vecs[13] = '{4'd3,  0,  0, 14,  1, 0, 32'd0,         32'hFFFF_FFFF, 0, 0, 0};
    vecs[14] = '{4'd13, 1,  2, 15,  1, 0, 32'd0,         32'd0,         1, 0, 0};
    vecs[15] = '{4'd5,  1,  2, 16,  1, 0, 32'd0,         32'hFFFF_FFFD, 0, 0, 1};
    vecs[16] = '{4'd11, 3,  0, 17,  1, 1, 32'd0,         32'h7FFF_FFFF, 0, 0, 0};
    vecs[17] = '{4'd5,  4,  0, 18,  1, 1, 32'd1,         32'h7FFF_FFFF, 0, 1, 0};

    Reset_n = 1'b0; In_Valid = 1'b0; ALU_OP = '0; R_Addr_A = '0; R_Addr_B = '0;
    W_Addr = '0; Write_Reg = 1'b0; Use_Imm = 1'b0; Imm = '0; Clear_Flags = 1'b0;
    R_Addr_C = '0;
    do_reset(3);

    // Directed vectors issued back to back; vector i's output appears one step later.
    for (int i = 0; i < NV; i++) begin
      step(1'b1, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].wa, vecs[i].wr, vecs[i].ui,
           vecs[i].imm, 1'b0, (i == 0) ? AW'(0) : vecs[i-1].wa);
      if (i > 0) table_check(i - 1);
    end
    idle(1'b0, vecs[NV-1].wa);
    table_check(NV - 1);
    idle(1'b0, 5'd2);
    check("fwd_r2", R_Data_C, 32'd8);
    idle(1'b0, 5'd0);
    check("r0_after_write", R_Data_C, 32'd0);

    // Clear drops the sticky flag when no overflow is coming out.
    idle(1'b1, 5'd4);
    check("sticky_cleared", W'(OF_Sticky), 32'd0);

    // Overflow emerging on the same edge as a clear keeps the flag set.
    step(1'b1, 4'd1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 5'd0);
    step(1'b1, 4'd4, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 32'd1, 1'b0, 5'd0);
    idle(1'b1, 5'd3);
    check("set_wins", W'(OF_Sticky), 32'd1);
    idle(1'b1, 5'd3);
    check("clear_after", W'(OF_Sticky), 32'd0);

    // Random writes, then a held reset must wipe every register.
    for (int i = 0; i < 40; i++)
      step(1'b1, 4'd1, AW'($urandom), 5'd0, AW'($urandom_range(1, D - 1)), 1'b1, 1'b1,
           $urandom, 1'b0, AW'($urandom));
    idle(1'b0, 5'd1);
    do_reset(3);

    // Reset between two in-flight operations: nothing may be written back.
    step(1'b1, 4'd1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 32'h55, 1'b0, 5'd0);
    step(1'b1, 4'd4, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 32'd1, 1'b0, 5'd7);
    check("mid_pre_valid", W'(Out_Valid), 32'd1);
    ALU_OP = 4'd4; R_Addr_A = 5'd7; W_Addr = 5'd9; Use_Imm = 1'b1; Imm = 32'd2;
    #2;
    do_reset(3);
    idle(1'b0, 5'd7);
    idle(1'b0, 5'd9);

    // Random traffic, biased towards dependent ops and boundary immediates.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] imm;
      case ($urandom_range(0, 5))
        0: imm = 32'h7FFF_FFFF;
        1: imm = 32'h8000_0000;
        2: imm = 32'hFFFF_FFFF;
        3: imm = W'($urandom_range(0, 40));
        default: imm = $urandom;
      endcase
      step($urandom_range(0, 9) < 8, 4'($urandom), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, imm, $urandom_range(0, 9) == 0, AW'($urandom_range(0, 7)));
    end
    idle(1'b0, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
